maxpool_2x2: RTL



---
 rtl/lenet_pkg.sv | 28 ++
 rtl/pool_max2.sv | 13 +
 rtl/maxpool_2x2.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/lenet_pkg.sv
// Shared LeNet-5 constants: element width, per-layer dimensions, buffer
// address widths and the pooling FSM state encoding.
package lenet_pkg;

  localparam int DATA_W = 8;

  localparam int C1_CH = 6;
  localparam int C1_HW = 28;
  localparam int P1_HW = 14;
  localparam int C2_CH = 16;
  localparam int C2_HW = 10;
  localparam int P2_HW = 5;

  localparam int BUF_A_AW = 13;
  localparam int BUF_B_AW = 11;
  localparam int BUF_C_AW = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_RD2,
    ST_RD3,
    ST_WR,
    ST_FIN
  } pool_state_t;

endpackage

// File: rtl/pool_max2.sv
// Combinational signed maximum of two W-bit two's-complement values.
module pool_max2 #(
  parameter int W = 8
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  // Ties resolve to a, which is the same value.
  assign y = (b > a) ? b : a;

endmodule

// File: rtl/maxpool_2x2.sv
// 2x2 stride-2 max-pool engine: five cycles per output (four reads, one write).
// Define POOL_RELU_EN to clamp negative pooled values to zero before writing.
module maxpool_2x2 #(
  parameter int CHANNELS = lenet_pkg::C1_CH,
  parameter int IN_H     = lenet_pkg::C1_HW,
  parameter int IN_W     = lenet_pkg::C1_HW,
  parameter int SRC_AW   = lenet_pkg::BUF_A_AW,
  parameter int DST_AW   = lenet_pkg::BUF_B_AW,
  parameter int DATA_W   = lenet_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [DATA_W-1:0] src_rd_data,
  output logic [DST_AW-1:0] dst_addr,
  output logic [DATA_W-1:0] dst_wr_data,
  output logic              dst_wr_en
);
  import lenet_pkg::*;

  localparam int OH = IN_H / 2;
  localparam int OW = IN_W / 2;

  pool_state_t              state_q;
  logic [15:0]              c_q, r_q, col_q;
  logic [SRC_AW-1:0]        win_base_q;
  logic [DST_AW-1:0]        out_idx_q;
  logic signed [DATA_W-1:0] acc_q;

  logic signed [DATA_W-1:0] rd_s, max_v, wr_v;
  logic                     last_col, last_row, last_ch;
  logic [SRC_AW-1:0]        next_base;

  assign rd_s = src_rd_data;

  pool_max2 #(.W(DATA_W)) u_max (
    .a (acc_q),
    .b (rd_s),
    .y (max_v)
  );

`ifdef POOL_RELU_EN
  assign wr_v = max_v[DATA_W-1] ? '0 : max_v;
`else
  assign wr_v = max_v;
`endif

  assign last_col = (col_q == 16'(OW - 1));
  assign last_row = (r_q == 16'(OH - 1));
  assign last_ch  = (c_q == 16'(CHANNELS - 1));

  // Stepping past the last window of a row (or channel) skips the odd row
  // below it; rows and channels are contiguous, so one adder covers both.
  assign next_base = last_col ? win_base_q + SRC_AW'(IN_W + 2)
                              : win_base_q + SRC_AW'(2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      dst_wr_en   <= 1'b0;
      src_addr    <= '0;
      dst_addr    <= '0;
      dst_wr_data <= '0;
      c_q         <= '0;
      r_q         <= '0;
      col_q       <= '0;
      win_base_q  <= '0;
      out_idx_q   <= '0;
      acc_q       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; the pulses below
      // default low each cycle and are raised only by the state that owns them.
      done      <= 1'b0;
      dst_wr_en <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_RD0;
            busy       <= 1'b1;
            c_q        <= '0;
            r_q        <= '0;
            col_q      <= '0;
            win_base_q <= '0;
            out_idx_q  <= '0;
            src_addr   <= '0;
          end
        end
        ST_RD0: begin
          acc_q    <= rd_s;
          src_addr <= win_base_q + SRC_AW'(1);
          state_q  <= ST_RD1;
        end
        ST_RD1: begin
          acc_q    <= max_v;
          src_addr <= win_base_q + SRC_AW'(IN_W);
          state_q  <= ST_RD2;
        end
        ST_RD2: begin
          acc_q    <= max_v;
          src_addr <= win_base_q + SRC_AW'(IN_W + 1);
          state_q  <= ST_RD3;
        end
        ST_RD3: begin
          acc_q       <= max_v;
          dst_wr_data <= wr_v;
          dst_addr    <= out_idx_q;
          dst_wr_en   <= 1'b1;
          state_q     <= ST_WR;
        end
        ST_WR: begin
          out_idx_q  <= out_idx_q + DST_AW'(1);
          win_base_q <= next_base;
          src_addr   <= next_base;
          if (last_col) begin
            col_q <= '0;
            if (last_row) begin
              r_q <= '0;
              c_q <= c_q + 16'd1;
            end else begin
              r_q <= r_q + 16'd1;
            end
          end else begin
            col_q <= col_q + 16'd1;
          end
          if (last_col && last_row && last_ch) begin
            state_q <= ST_FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_q <= ST_RD0;
          end
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
